// File: rtl/xoodyak_absorb_packer.sv
// xoodyak_absorb_packer
// Packs a byte-serial message into 16-byte Xoodyak hash rate blocks and
// applies per-block padding. Each block goes out with first/last flags over a
// valid/ready handshake. An empty message yields one padding-only block.
// Optional build macro XOODYAK_ABSORB_CD_EN: when defined, blk_cd carries the
// hash-mode Cd byte (0x03) on the first block. Otherwise blk_cd is tied to 0.
module xoodyak_absorb_packer #(
    parameter int RATE_BYTES = 16,
    parameter int LEN_W      = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             load,
    input  logic [7:0]       msg,
    output logic             busy,
    output logic [127:0]     blk_data,
    output logic             blk_pad16,
    output logic             blk_first,
    output logic             blk_last,
    output logic [7:0]       blk_cd,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [4:0] FULL_IDX = 5'(RATE_BYTES);
    localparam logic [4:0] LAST_IDX = 5'(RATE_BYTES - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [4:0]       bidx_q, bidx_d;
    logic             first_pend_q, first_pend_d;
    logic [7:0]       buf_q [RATE_BYTES];
    logic [7:0]       buf_d [RATE_BYTES];

    logic block_complete;
    logic accept_byte;
    logic clear_buf;
    logic emitting;

    // Block is ready to emit once it is full or the message has run out.
    assign block_complete = (bidx_q == FULL_IDX) || (rem_q == '0);
    assign accept_byte    = (state_q == S_COLLECT) && load && !block_complete;
    assign emitting       = (state_q == S_EMIT);

    // Next-state logic and counter updates for the packing FSM.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        bidx_d       = bidx_q;
        first_pend_d = first_pend_q;
        clear_buf    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d        = msg_len;
                    bidx_d       = '0;
                    first_pend_d = 1'b1;
                    clear_buf    = 1'b1;
                    state_d      = (msg_len == '0) ? S_EMIT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept_byte) begin
                    bidx_d = bidx_q + 5'd1;
                    rem_d  = rem_q - 1'b1;
                    // Go straight to EMIT so valid appears the cycle after
                    // the block's final byte is taken.
                    if ((rem_q == LEN_W'(1)) || (bidx_q == LAST_IDX)) begin
                        state_d = S_EMIT;
                    end
                end else if (block_complete) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    first_pend_d = 1'b0;
                    bidx_d       = '0;
                    clear_buf    = 1'b1;
                    state_d      = (rem_q == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; an asynchronous reset drops any message in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            bidx_q       <= '0;
            first_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            bidx_q       <= bidx_d;
            first_pend_q <= first_pend_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RATE_BYTES; gi++) begin : g_byte
            // Byte lane gi captures the message byte when it is the write slot.
            always_comb begin
                buf_d[gi] = buf_q[gi];
                if (clear_buf) begin
                    buf_d[gi] = 8'h00;
                end else if (accept_byte && (bidx_q == 5'(gi))) begin
                    buf_d[gi] = msg;
                end
            end

            // Byte lane storage.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    buf_q[gi] <= 8'h00;
                end else begin
                    buf_q[gi] <= buf_d[gi];
                end
            end

            // Data bytes below the fill index. The 0x01 pad sits at the fill
            // index, and zeros follow it. A full block has no pad in range.
            assign blk_data[8*gi +: 8] =
                !emitting                ? 8'h00 :
                (5'(gi) <  bidx_q)       ? buf_q[gi] :
                (5'(gi) == bidx_q)       ? 8'h01 : 8'h00;
        end
    endgenerate

    assign busy      = !((state_q == S_COLLECT) && !block_complete);
    assign blk_valid = emitting;
    assign blk_pad16 = emitting && (bidx_q == FULL_IDX);
    assign blk_first = emitting && first_pend_q;
    assign blk_last  = emitting && (rem_q == '0);
    assign done      = (state_q == S_DONE);

`ifdef XOODYAK_ABSORB_CD_EN
    assign blk_cd = blk_first ? 8'h03 : 8'h00;
`else
    assign blk_cd = 8'h00;
`endif

endmodule

// File: tb/tb_xoodyak_absorb_packer.sv
// Self-checking bench for xoodyak_absorb_packer. A block-level model builds the
// expected padded blocks from each message. A compare process checks every
// valid cycle against that model. Literal expectations pin key results.
module tb_xoodyak_absorb_packer;

    localparam int LEN_W = 12;
`ifdef XOODYAK_ABSORB_CD_EN
    localparam logic [7:0] CD_FIRST = 8'h03;
`else
    localparam logic [7:0] CD_FIRST = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             load;
    logic [7:0]       msg;
    logic             busy;
    logic [127:0]     blk_data;
    logic             blk_pad16;
    logic             blk_first;
    logic             blk_last;
    logic [7:0]       blk_cd;
    logic             blk_valid;
    logic             blk_ready;
    logic             done;

    xoodyak_absorb_packer #(.RATE_BYTES(16), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .msg_len   (msg_len),
        .load      (load),
        .msg       (msg),
        .busy      (busy),
        .blk_data  (blk_data),
        .blk_pad16 (blk_pad16),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_cd    (blk_cd),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         pad16;
        logic         first;
        logic         last;
        logic [7:0]   cd;
    } blk_t;

    blk_t         exp_q[$];
    logic [7:0]   msg_bytes [64];
    int           checks = 0;
    int           errors = 0;
    int           n_acc = 0;
    int           msg_cnt = 0;
    logic         chk_en = 1'b0;
    logic         done_due = 1'b0;
    logic [127:0] acc_data;
    logic [7:0]   acc_cd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected blocks derived directly from the message bytes and length.
    task automatic model_push(input int len);
        int nblk;
        nblk = (len == 0) ? 1 : (len + 15) / 16;
        for (int b = 0; b < nblk; b++) begin
            blk_t e;
            int   cnt;
            cnt = len - 16 * b;
            if (cnt > 16) cnt = 16;
            e.data = '0;
            for (int k = 0; k < cnt; k++) e.data[8*k +: 8] = msg_bytes[16*b + k];
            if (cnt < 16) e.data[8*cnt +: 8] = 8'h01;
            e.pad16 = (cnt == 16);
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            e.cd    = (b == 0) ? CD_FIRST : 8'h00;
            exp_q.push_back(e);
        end
    endtask

    // Compare DUT outputs against the model on every valid cycle. Also track
    // block acceptance and the done pulse.
    always @(negedge clk) begin
        if (chk_en) begin
            if (done_due) begin
                chk("done_pulse", done, 1'b1);
                done_due = 1'b0;
                msg_cnt++;
            end else begin
                chk("done_idle", done, 1'b0);
            end
            if (blk_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", blk_valid, 1'b0);
                end else begin
                    chk("blk_data",  blk_data,  exp_q[0].data);
                    chk("blk_pad16", blk_pad16, exp_q[0].pad16);
                    chk("blk_first", blk_first, exp_q[0].first);
                    chk("blk_last",  blk_last,  exp_q[0].last);
                    chk("blk_cd",    blk_cd,    exp_q[0].cd);
                    chk("busy_emit", busy,      1'b1);
                    if (blk_ready) begin
                        acc_data = blk_data;
                        acc_cd   = blk_cd;
                        n_acc++;
                        $display("block accept #%0d data=%h pad16=%0b first=%0b last=%0b cd=%h",
                                 n_acc, blk_data, blk_pad16, blk_first, blk_last, blk_cd);
                        if (exp_q[0].last) done_due = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One-cycle start pulse; the model is loaded before the DUT can emit.
    task automatic do_start(input int len, input logic ld);
        model_push(len);
        @(posedge clk); #1;
        start = 1'b1; msg_len = LEN_W'(len); load = ld; msg = 8'hEE;
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0;
    endtask

    // Offer bytes in order. A byte advances only on an edge where load=1 and
    // busy=0. An optional stray start pulse is issued on cycle start_at.
    task automatic drive_bytes(input int n, input bit toggle, input int start_at);
        int  i;
        int  cyc;
        logic consumed;
        i = 0; cyc = 0;
        while (i < n && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start   = (cyc == start_at);
            if (cyc == start_at) msg_len = LEN_W'(9);
            load    = toggle ? (cyc % 2 == 1) : 1'b1;
            msg     = msg_bytes[i];
            @(negedge clk);
            consumed = load && !busy;
            if (consumed) i++;
        end
        if (i < n) chk("drive_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
    endtask

    task automatic wait_msg();
        int target;
        target = msg_cnt + 1;
        for (int c = 0; c < 400; c++) begin
            if (msg_cnt >= target) break;
            @(posedge clk);
        end
        if (msg_cnt < target) chk("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        resetn = 1'b0; start = 1'b0; msg_len = '0; load = 1'b0; msg = 8'h00; blk_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",  busy,      1'b1);
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_data",  blk_data,  128'h0);
        chk("rst_flags", {blk_pad16, blk_first, blk_last}, 3'b000);
        chk("rst_cd",    blk_cd,    8'h00);
        #2 resetn = 1'b1;
        chk_en = 1'b1;

        // Empty message: one pad-only block one cycle after start.
        base = n_acc;
        do_start(0, 1'b0);
        @(negedge clk);
        chk("t0_valid_latency", blk_valid, 1'b1);
        wait_msg();
        chk("t0_data", acc_data, 128'h01);
        chk("t0_cd",   acc_cd,   CD_FIRST);
        chk("t0_nblk", n_acc - base, 1);

        // One byte; load held during start must not consume a byte.
        msg_bytes[0] = 8'hA5;
        base = n_acc;
        do_start(1, 1'b1);
        drive_bytes(1, 1'b0, -1);
        wait_msg();
        chk("t1_data", acc_data, 128'h01A5);
        chk("t1_nblk", n_acc - base, 1);

        // Exactly one full block, no trailing empty block.
        for (int k = 0; k < 16; k++) msg_bytes[k] = 8'(k);
        base = n_acc;
        do_start(16, 1'b0);
        drive_bytes(16, 1'b0, -1);
        wait_msg();
        chk("t16_data", acc_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t16_nblk", n_acc - base, 1);

        // 17 bytes with a 5-cycle stall on block 1.
        for (int k = 0; k < 17; k++) msg_bytes[k] = 8'(k);
        base = n_acc;
        blk_ready = 1'b0;
        do_start(17, 1'b0);
        fork
            drive_bytes(17, 1'b0, -1);
            begin
                for (int c = 0; c < 100 && !blk_valid; c++) @(negedge clk);
                chk("t17_stall_seen", blk_valid, 1'b1);
                repeat (5) begin
                    @(negedge clk);
                    chk("t17_stall_busy", busy, 1'b1);
                end
                @(posedge clk); #1;
                blk_ready = 1'b1;
            end
        join
        wait_msg();
        chk("t17_data2", acc_data, 128'h0110);
        chk("t17_cd2",   acc_cd,   8'h00);
        chk("t17_nblk",  n_acc - base, 2);

        // Toggled load and a stray start mid-collect.
        msg_bytes[0] = 8'h11; msg_bytes[1] = 8'h22; msg_bytes[2] = 8'h33;
        msg_bytes[3] = 8'h44; msg_bytes[4] = 8'h55;
        base = n_acc;
        do_start(5, 1'b0);
        drive_bytes(5, 1'b1, 3);
        wait_msg();
        chk("t5_data", acc_data, 128'h015544332211);
        chk("t5_nblk", n_acc - base, 1);

        // Reset in the middle of a 20-byte message.
        for (int k = 0; k < 20; k++) msg_bytes[k] = 8'(8'h80 + k);
        do_start(20, 1'b0);
        drive_bytes(7, 1'b0, -1);
        chk_en = 1'b0;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rr_busy",  busy,      1'b1);
        chk("rr_valid", blk_valid, 1'b0);
        chk("rr_data",  blk_data,  128'h0);
        chk("rr_flags", {done, blk_pad16, blk_first, blk_last, blk_cd}, 12'h000);
        exp_q.delete();
        done_due = 1'b0;
        @(negedge clk); #1;
        resetn = 1'b1;
        chk_en = 1'b1;
        msg_bytes[0] = 8'hAA; msg_bytes[1] = 8'hBB; msg_bytes[2] = 8'hCC;
        base = n_acc;
        do_start(3, 1'b0);
        drive_bytes(3, 1'b0, -1);
        wait_msg();
        chk("rr_new_data", acc_data, 128'h01CCBBAA);
        chk("rr_new_nblk", n_acc - base, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xoodyak_absorb_packer.md
Name: xoodyak_absorb_packer

Overview:
- Upstream stage of the Xoodyak hash core.
- Accepts the message one byte at a time under a load/busy handshake. Packs the bytes into 16-byte rate blocks and applies Xoodyak per-block padding.
- Presents each padded block with first/last flags to the absorb/permutation controller through a valid/ready handshake.
- Empty messages produce exactly one padding-only block.

Parameters:
- RATE_BYTES, 16, bytes per absorbed block (Xoodyak hash rate); logic written for 16, other values unsupported.
- LEN_W, 12, width of msg_len and internal byte counters.

Ports:
- clk  in  1  system clock, all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches msg_len and begins a message (honoured only in IDLE)
- msg_len  in  LEN_W  message length in bytes, 0..4095
- load  in  1  upstream byte-present qualifier
- msg  in  8  message byte
- busy  out  1  high = byte on msg not accepted this cycle
- blk_data  out  128  padded rate block; byte k on bits [8k+7:8k]
- blk_pad16  out  1  block holds 16 data bytes; pad byte 0x01 belongs at state byte 16
- blk_first  out  1  block is first of message
- blk_last  out  1  block is last of message
- blk_cd  out  8  domain byte for state byte 47 (see Optional Feature)
- blk_valid  out  1  block outputs stable and valid
- blk_ready  in  1  downstream accepts block
- done  out  1  one-cycle pulse after last block accepted

Behaviour:
- Reset values: busy=1, blk_valid=0, done=0, blk_data=0, blk_pad16=0, blk_first=0, blk_last=0, blk_cd=0. State is IDLE and all counters are 0.
- Reset is asynchronous and abandons any message in progress; no partial block is emitted.
- IDLE:
  - busy=1.
  - On start: latch rem=msg_len, clear byte index bidx=0, set first_pend=1.
  - If msg_len=0, go to EMIT with blk_data=0x01 in byte 0, blk_pad16=0 and blk_last=1.
  - Otherwise go to COLLECT.
- COLLECT:
  - busy=0 unless the block is complete.
  - A byte is accepted on a rising edge where load=1 and busy=0. It is written to byte bidx, then bidx++ and rem--.
  - When rem reaches 0 or bidx reaches 16, go to EMIT on the next cycle; busy=1 from that cycle on.
  - Pad insertion for a partial final block (bidx<16): byte bidx is set to 0x01 and all higher bytes are 0, with blk_pad16=0.
  - For a full block: blk_pad16=1.
  - blk_last=1 iff rem=0.
  - Latency: blk_valid rises one cycle after the edge that accepted the block's final byte.
- EMIT:
  - blk_valid=1 and busy=1. Outputs are held stable until the cycle where blk_valid&&blk_ready.
  - On accept: clear first_pend and bidx, and zero the data buffer.
  - If blk_last, go to DONE. Otherwise go to COLLECT.
  - blk_ready while blk_valid=0 has no effect.
- DONE: done=1 for one cycle, then IDLE.
- Block count is max(1, ceil(msg_len/16)). msg_len a multiple of 16 gives no extra empty block; the last block is full with blk_pad16=1.
- start while not in IDLE is ignored. load in IDLE/EMIT/DONE is ignored, so no byte is consumed.
- start and load in the same cycle in IDLE: start is honoured and the byte is not consumed.
- rem and bidx never wrap. Accepting a byte is impossible when rem=0.

Optional Feature:
- Macro XOODYAK_ABSORB_CD_EN.
- Defined: blk_cd=8'h03 when blk_first=1, else 8'h00 (Xoodyak hash-mode Cd for the first absorbed block).
- Undefined: blk_cd is constant 8'h00 and the downstream controller applies Cd itself. Port list is unchanged in both builds.

Test Plan:
- msg_len=0, start pulse, blk_ready=1:
  - EMIT follows start by one cycle with blk_data=128'h01, blk_first=1, blk_last=1, blk_pad16=0.
  - done follows accept by one cycle.
  - blk_cd=8'h03 with macro, 8'h00 without.
- msg_len=1, byte 0xA5: blk_data=128'h01A5, blk_first=1, blk_last=1, blk_pad16=0, one block only.
- msg_len=16, bytes 0x00..0x0F: one block, blk_data=128'h0F0E...0100, blk_pad16=1, blk_last=1, no second block.
- msg_len=17, bytes 0x00..0x10, blk_ready held 0 for 5 cycles on block 1:
  - busy stays 1 and blk_data stays stable through the stall.
  - Block 1 is full with first=1, last=0.
  - Block 2 is blk_data=128'h0110 with first=0, last=1, and blk_cd=0 in both builds.
- Stimulus: load toggled every other cycle over msg_len=5, plus a start pulse issued mid-COLLECT.
  - Only edges with load=1 && busy=0 consume bytes.
  - The second start is ignored.
  - Result: blk_data=128'h01_XXXXXXXXXX, i.e. byte 5=0x01 above the 5 data bytes in order.
- resetn asserted during COLLECT after 7 of 20 bytes: all outputs return to reset values immediately. A new start with msg_len=3 then yields a clean single block with no stale bytes.
